csr_file: RTL

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs (mstatus/mie/mtvec/mepc/mip) with interrupt entry and mret; reads are combinational, writes land at the edge.
// No backpressure: stall only gates trap entry, mret and retire counting. Define CSR_COUNTER_EN to add mcycle/minstret and their user aliases.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        inst_retire,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic        trap_take,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mip_meip;
    logic        mip_mtip;
    logic [31:2] mtvec_q;
    logic [31:2] mepc_q;
    logic        mret_go;
    logic        wr_mstatus;
    logic        wr_mepc;

    assign trap_take   = ~rst & mstatus_mie & ((mie_meie & mip_meip) | (mie_mtie & mip_mtip))
                         & ~stall & ~mret;
    assign mret_go     = mret & ~stall;
    assign wr_mstatus  = csr_wen & (csr_addr == ADDR_MSTATUS);
    assign wr_mepc     = csr_wen & (csr_addr == ADDR_MEPC);
    assign trap_vector = {mtvec_q, 2'b00};
    assign mepc_out    = {mepc_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mip_meip     <= 1'b0;
            mip_mtip     <= 1'b0;
            mtvec_q      <= MTVEC_RST[31:2];
            mepc_q       <= '0;
        end else begin
            mip_meip <= ext_irq;
            mip_mtip <= timer_irq;
            if (csr_wen && csr_addr == ADDR_MIE) begin
                mie_meie <= csr_wdata[11];
                mie_mtie <= csr_wdata[7];
            end
            if (csr_wen && csr_addr == ADDR_MTVEC) begin
                mtvec_q <= csr_wdata[31:2];
            end
            // trap entry and mret own mstatus over a software write in the same cycle
            if (trap_take) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_go) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mstatus_mie  <= csr_wdata[3];
                mstatus_mpie <= csr_wdata[7];
            end
            if (trap_take) begin
                mepc_q <= pc[31:2];
            end else if (wr_mepc) begin
                mepc_q <= csr_wdata[31:2];
            end
        end
    end

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // a write to either half freezes the whole counter for that cycle, so no carry leaks across
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_wen && csr_addr == ADDR_MCYCLE) begin
                mcycle[31:0] <= csr_wdata;
            end else if (csr_wen && csr_addr == ADDR_MCYCLEH) begin
                mcycle[63:32] <= csr_wdata;
            end else begin
                mcycle <= mcycle + 64'd1;
            end
            if (csr_wen && csr_addr == ADDR_MINSTRET) begin
                minstret[31:0] <= csr_wdata;
            end else if (csr_wen && csr_addr == ADDR_MINSTRETH) begin
                minstret[63:32] <= csr_wdata;
            end else if (inst_retire && !stall) begin
                minstret <= minstret + 64'd1;
            end
        end
    end
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            ADDR_MIE: begin
                csr_rdata[11] = mie_meie;
                csr_rdata[7]  = mie_mtie;
            end
            ADDR_MTVEC: csr_rdata = trap_vector;
            ADDR_MEPC:  csr_rdata = mepc_out;
            ADDR_MIP: begin
                csr_rdata[11] = mip_meip;
                csr_rdata[7]  = mip_mtip;
            end
`ifdef CSR_COUNTER_EN
            ADDR_MCYCLE,   ADDR_CYCLE:    csr_rdata = mcycle[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_rdata = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  csr_rdata = minstret[31:0];
            ADDR_MINSTRETH,ADDR_INSTRETH: csr_rdata = minstret[63:32];
`endif
            default: csr_rdata = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{pc[1:0], csr_wdata[1:0], inst_retire,
                           ADDR_CYCLE, ADDR_CYCLEH, ADDR_INSTRET, ADDR_INSTRETH,
                           ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH};

endmodule
